// File: rtl/mdom_wvb_hdr_serializer_pkg.sv
// -----------------------------------------------------------------------------
// mdom_wvb_hdr_serializer_pkg
//  Shared definitions for the mDOM waveform-buffer header serializer:
//  bundle field offsets, word/length widths, FSM state type and helpers that
//  compute the waveform length and select one output word from a held header.
// -----------------------------------------------------------------------------
package mdom_wvb_hdr_serializer_pkg;

    localparam int P_W        = 112;   // bundle zero-extended to 7 whole words
    localparam int N_WORDS    = 8;     // 7 header words + 1 length word
    localparam int LEN_W      = 13;    // length range 1..4096
    localparam int ADDR_W     = 12;    // waveform buffer address width
    localparam int START_LSB  = 49;    // start_addr[60:49]
    localparam int STOP_LSB   = 61;    // stop_addr[72:61]

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Waveform length in samples; the buffer is circular, so the difference
    // is taken modulo 4096 and stop == start means a single sample.
    function automatic logic [LEN_W-1:0] calc_len(
        input logic [ADDR_W-1:0] start_addr,
        input logic [ADDR_W-1:0] stop_addr
    );
        logic [ADDR_W-1:0] diff;
        diff = stop_addr - start_addr;
        return {1'b0, diff} + 13'd1;
    endfunction

    // Word k of a packet: words 0..6 walk the held header MSB first,
    // word 7 carries the computed length.
    function automatic logic [15:0] word_sel(
        input logic [P_W-1:0]   p,
        input logic [LEN_W-1:0] len,
        input logic [2:0]       k
    );
        logic [15:0] w;
        case (k)
            3'd0:    w = p[111:96];
            3'd1:    w = p[95:80];
            3'd2:    w = p[79:64];
            3'd3:    w = p[63:48];
            3'd4:    w = p[47:32];
            3'd5:    w = p[31:16];
            3'd6:    w = p[15:0];
            3'd7:    w = {3'b000, len};
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/mdom_wvb_hdr_serializer.sv
// -----------------------------------------------------------------------------
// mdom_wvb_hdr_serializer
//  Accepts one 106-bit waveform-buffer header per valid/ready handshake and
//  emits it as 8 x 16-bit words (7 header words MSB first, then the waveform
//  length) with start/end-of-packet flags.
//
//  Ports
//   clk, rst              clock, asynchronous active-high reset
//   hdr_bundle/valid/ready header input handshake
//   dout, dout_valid       serialised word stream (registered)
//   dout_sop, dout_eop     first / last word of a packet (registered)
//   dout_ready             downstream accept
//   busy                   a packet is in flight
//   hdr_cnt                headers fully sent, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module mdom_wvb_hdr_serializer
    import mdom_wvb_hdr_serializer_pkg::*;
#(
    parameter int BUNDLE_W = 106,
    parameter int WORD_W   = 16,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BUNDLE_W-1:0] hdr_bundle,
    input  logic                hdr_valid,
    output logic                hdr_ready,
    output logic [WORD_W-1:0]   dout,
    output logic                dout_valid,
    output logic                dout_sop,
    output logic                dout_eop,
    input  logic                dout_ready,
    output logic                busy,
    output logic [CNT_W-1:0]    hdr_cnt
);

    state_t              state_r;
    logic [2:0]          idx_r;
    logic [P_W-1:0]      hold_r;
    logic [LEN_W-1:0]    len_r;
    logic [WORD_W-1:0]   dout_r;
    logic                dout_valid_r;
    logic                sop_r;
    logic                eop_r;
    logic [CNT_W-1:0]    hdr_cnt_r;

    logic                accept_s;
    logic [P_W-1:0]      p_in_s;
    logic [LEN_W-1:0]    len_in_s;

    // Ready while idle, or on the last word of a packet when that word is
    // being taken; this lets headers stream back-to-back at 8 cycles each.
    assign hdr_ready = (state_r == ST_IDLE) |
                       ((state_r == ST_SEND) & (idx_r == 3'd7) & dout_ready);
    assign accept_s  = hdr_valid & hdr_ready;

    assign p_in_s   = {{(P_W-BUNDLE_W){1'b0}}, hdr_bundle};
    assign len_in_s = calc_len(hdr_bundle[START_LSB +: ADDR_W],
                               hdr_bundle[STOP_LSB  +: ADDR_W]);

    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign dout_sop   = sop_r;
    assign dout_eop   = eop_r;
    assign hdr_cnt    = hdr_cnt_r;
    assign busy       = (state_r == ST_SEND);

    // Serializer FSM with registered word/flag outputs; the output registers
    // are loaded with the word for the index being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            idx_r        <= 3'd0;
            hold_r       <= '0;
            len_r        <= '0;
            dout_r       <= '0;
            dout_valid_r <= 1'b0;
            sop_r        <= 1'b0;
            eop_r        <= 1'b0;
            hdr_cnt_r    <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        hold_r       <= p_in_s;
                        len_r        <= len_in_s;
                        idx_r        <= 3'd0;
                        state_r      <= ST_SEND;
                        dout_r       <= p_in_s[P_W-1 -: WORD_W];
                        dout_valid_r <= 1'b1;
                        sop_r        <= 1'b1;
                        eop_r        <= 1'b0;
                    end else begin
                        state_r      <= ST_IDLE;
                    end
                end
                ST_SEND: begin
                    if (dout_ready) begin
                        if (idx_r == 3'd7) begin
                            hdr_cnt_r <= hdr_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                            if (accept_s) begin
                                // Chain straight into the next header.
                                hold_r       <= p_in_s;
                                len_r        <= len_in_s;
                                idx_r        <= 3'd0;
                                dout_r       <= p_in_s[P_W-1 -: WORD_W];
                                dout_valid_r <= 1'b1;
                                sop_r        <= 1'b1;
                                eop_r        <= 1'b0;
                            end else begin
                                state_r      <= ST_IDLE;
                                idx_r        <= 3'd0;
                                dout_r       <= '0;
                                dout_valid_r <= 1'b0;
                                sop_r        <= 1'b0;
                                eop_r        <= 1'b0;
                            end
                        end else begin
                            idx_r  <= idx_r + 3'd1;
                            dout_r <= word_sel(hold_r, len_r, idx_r + 3'd1);
                            sop_r  <= 1'b0;
                            eop_r  <= (idx_r == 3'd6);
                        end
                    end else begin
                        // Stalled: every output register holds.
                        state_r <= ST_SEND;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    dout_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdom_wvb_hdr_serializer.sv
// -----------------------------------------------------------------------------
// tb_mdom_wvb_hdr_serializer
//  Self-checking bench: every accepted header is expanded by a reference model
//  into its 8 expected words (with packet position) in a queue; each cycle the
//  DUT outputs are compared against the head of that queue.
// -----------------------------------------------------------------------------
module tb_mdom_wvb_hdr_serializer;

    localparam int CNT_W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [105:0]      hdr_bundle = '0;
    logic              hdr_valid = 1'b0;
    logic              hdr_ready;
    logic [15:0]       dout;
    logic              dout_valid;
    logic              dout_sop;
    logic              dout_eop;
    logic              dout_ready = 1'b1;
    logic              busy;
    logic [CNT_W-1:0]  hdr_cnt;

    always #5 clk = ~clk;

    mdom_wvb_hdr_serializer #(
        .BUNDLE_W (106),
        .WORD_W   (16),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .hdr_bundle (hdr_bundle),
        .hdr_valid  (hdr_valid),
        .hdr_ready  (hdr_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_sop   (dout_sop),
        .dout_eop   (dout_eop),
        .dout_ready (dout_ready),
        .busy       (busy),
        .hdr_cnt    (hdr_cnt)
    );

    typedef struct {
        logic [15:0] w;
        int          pos;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          exp_cnt = 0;
    int          valid_cycles = 0;
    logic        accepted = 1'b0;
    logic [15:0] last_eop_word = '0;
    logic        stall_prev = 1'b0;
    logic [15:0] prev_dout = '0;
    logic        prev_sop = 1'b0;
    logic        prev_eop = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [105:0] make_bundle(input logic [48:0] ltc,
                                                 input logic [11:0] s,
                                                 input logic [11:0] e);
        logic [105:0] b;
        b[31:0]   = $urandom();
        b[63:32]  = $urandom();
        b[95:64]  = $urandom();
        b[105:96] = 10'($urandom());
        b[48:0]   = ltc;
        b[60:49]  = s;
        b[72:61]  = e;
        return b;
    endfunction

    // Reference: packet = 7 sixteen-bit slices of the zero-extended bundle,
    // most significant first, then the circular-buffer length.
    task automatic push_header(input logic [105:0] b);
        logic [111:0] p;
        logic [111:0] tmp;
        int s_i, e_i, len;
        p   = {6'b0, b};
        s_i = int'(b[60:49]);
        e_i = int'(b[72:61]);
        len = ((e_i - s_i + 4096) % 4096) + 1;
        for (int k = 0; k < 7; k++) begin
            tmp = p >> (16 * (6 - k));
            q.push_back('{tmp[15:0], k});
        end
        q.push_back('{16'(len), 7});
    endtask

    task automatic check_cycle();
        logic exp_ready;
        logic in_flight;
        in_flight = (q.size() != 0);
        exp_ready = !in_flight || (q[0].pos == 7 && dout_ready);
        chk("dout_valid", dout_valid, in_flight);
        chk("busy", busy, in_flight);
        chk("hdr_ready", hdr_ready, exp_ready);
        chk("hdr_cnt", hdr_cnt, 32'(exp_cnt % (1 << CNT_W)));
        if (stall_prev) begin
            chk("stall_dout", dout, prev_dout);
            chk("stall_sop", dout_sop, prev_sop);
            chk("stall_eop", dout_eop, prev_eop);
        end
        if (in_flight) begin
            chk("dout", dout, q[0].w);
            chk("sop", dout_sop, q[0].pos == 0);
            chk("eop", dout_eop, q[0].pos == 7);
            valid_cycles++;
        end
        stall_prev = in_flight && !dout_ready;
        prev_dout  = dout;
        prev_sop   = dout_sop;
        prev_eop   = dout_eop;
        if (in_flight && dout_ready) begin
            if (q[0].pos == 7) begin
                exp_cnt++;
                last_eop_word = dout;
            end
            void'(q.pop_front());
        end
        accepted = hdr_valid && exp_ready;
        if (accepted) push_header(hdr_bundle);
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_hdr(input logic [105:0] b, input bit keep_valid, input bit rand_ready);
        int n;
        hdr_bundle = b;
        hdr_valid  = 1'b1;
        n = 0;
        do begin
            if (rand_ready) dout_ready = ($urandom() % 4) != 0;
            tick();
            n++;
        end while (!accepted && n < 200);
        if (!accepted) chk("accept_timeout", 32'd0, 32'd1);
        if (!keep_valid) hdr_valid = 1'b0;
    endtask

    task automatic drain(input bit rand_ready);
        int n;
        n = 0;
        while (q.size() != 0 && n < 400) begin
            if (rand_ready) dout_ready = ($urandom() % 4) != 0;
            tick();
            n++;
        end
        dout_ready = 1'b1;
        if (q.size() != 0) chk("drain_timeout", q.size(), 32'd0);
        tick();
    endtask

    task automatic wait_pos(input int pos);
        int n;
        n = 0;
        while (!(q.size() != 0 && q[0].pos == pos) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("wait_pos_timeout", 32'(pos), 32'hFFFF);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_dout_valid", dout_valid, 32'd0);
        chk("rst_dout", dout, 32'd0);
        chk("rst_eop", dout_eop, 32'd0);
        chk("rst_hdr_cnt", hdr_cnt, 32'd0);
        q.delete();
        exp_cnt    = 0;
        stall_prev = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rel_hdr_ready", hdr_ready, 32'd1);
        chk("rel_busy", busy, 32'd0);
        chk("rel_hdr_cnt", hdr_cnt, 32'd0);
    endtask

    initial begin
        do_reset();

        // Single header, full-rate downstream.
        send_hdr(make_bundle(49'h1_2345_6789_ABCD, 12'h010, 12'h01F), 1'b0, 1'b0);
        drain(1'b0);
        chk("t1_len_word", last_eop_word, 32'h0010);
        chk("t1_hdr_cnt", hdr_cnt, 32'd1);

        // Length wrap-around and boundaries.
        send_hdr(make_bundle(49'($urandom()), 12'hFF0, 12'h00F), 1'b0, 1'b0);
        drain(1'b0);
        chk("t2_wrap_len", last_eop_word, 32'h0020);
        send_hdr(make_bundle(49'($urandom()), 12'h100, 12'h0FF), 1'b0, 1'b0);
        drain(1'b0);
        chk("t2_max_len", last_eop_word, 32'h1000);
        send_hdr(make_bundle(49'($urandom()), 12'h345, 12'h345), 1'b0, 1'b0);
        drain(1'b0);
        chk("t2_min_len", last_eop_word, 32'h0001);

        // Directed backpressure at idx 2 and on the last word.
        send_hdr(make_bundle(49'($urandom()), 12'h200, 12'h27F), 1'b0, 1'b0);
        wait_pos(2);
        dout_ready = 1'b0;
        repeat (3) tick();
        dout_ready = 1'b1;
        wait_pos(7);
        dout_ready = 1'b0;
        repeat (2) tick();
        dout_ready = 1'b1;
        drain(1'b0);
        chk("t3_len_word", last_eop_word, 32'h0080);

        // Back-to-back: hdr_valid held high across four headers.
        do_reset();
        valid_cycles = 0;
        for (int i = 0; i < 4; i++)
            send_hdr(make_bundle(49'($urandom()), 12'($urandom()), 12'($urandom())), 1'b1, 1'b0);
        hdr_valid = 1'b0;
        drain(1'b0);
        chk("t4_valid_cycles", valid_cycles, 32'd32);
        chk("t4_hdr_cnt", hdr_cnt, 32'd4);

        // Reset in the middle of a packet.
        send_hdr(make_bundle(49'($urandom()), 12'h000, 12'h00A), 1'b0, 1'b0);
        wait_pos(4);
        do_reset();
        send_hdr(make_bundle(49'($urandom()), 12'h050, 12'h05F), 1'b0, 1'b0);
        drain(1'b0);
        chk("t5_len_word", last_eop_word, 32'h0010);
        chk("t5_hdr_cnt", hdr_cnt, 32'd1);

        // Counter wrap with a 4-bit counter: 17 headers -> 1.
        do_reset();
        for (int i = 0; i < 17; i++)
            send_hdr(make_bundle(49'($urandom()), 12'($urandom()), 12'($urandom())), 1'b1, 1'b0);
        hdr_valid = 1'b0;
        drain(1'b0);
        chk("t6_hdr_cnt_wrap", hdr_cnt, 32'd1);

        // Random headers, random gaps and random downstream stalls.
        for (int i = 0; i < 30; i++) begin
            send_hdr(make_bundle(49'($urandom()), 12'($urandom()), 12'($urandom())),
                     ($urandom() % 2) != 0, 1'b1);
            if (($urandom() % 3) == 0) begin
                hdr_valid = 1'b0;
                repeat ($urandom_range(1, 4)) begin
                    dout_ready = ($urandom() % 4) != 0;
                    tick();
                end
            end
        end
        hdr_valid = 1'b0;
        drain(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
